// File: rtl/mux8_rr_sched.sv
// Eight-channel round-robin burst scheduler: grants one requesting channel at a
// time and forwards up to BURST_LEN 1-bit beats from it downstream.
//
// Handshake: a beat is offered while out_valid is high and is transferred on a
// rising clk edge where out_valid and out_ready are both high; out_valid and
// out_data may change only when req/d change or the grant changes, and the
// block never waits for out_ready before raising out_valid.
module mux8_rr_sched #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] d,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       out_valid,
  output logic       out_data,
  output logic       busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic [7:0] r_gnt;
  logic [7:0] w_gnt_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic       w_found;
  logic [2:0] w_pick;
  logic [2:0] w_idx;

  // Wrapping search that starts at r_ptr; the first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = 8'h00;
        if (w_found) begin
          w_state_nxt = S_XFER;
          w_sel_nxt   = w_pick;
          w_gnt_nxt   = 8'b1 << w_pick;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_XFER: begin
        // Moving ptr past the finished channel is what keeps it from winning
        // the next arbitration while anyone else is requesting.
        if (!req[r_sel]) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_sel + 3'd1;
          w_gnt_nxt   = 8'h00;
        end else if (out_ready) begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = r_sel + 3'd1;
            w_gnt_nxt   = 8'h00;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd0;
      r_sel   <= 3'd0;
      r_gnt   <= 8'h00;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign busy      = (r_state == S_XFER);
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out_valid = busy & req[r_sel];
  assign out_data  = busy & d[r_sel];

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed and long-run checks for mux8_rr_sched: arbitration order, wrap,
// backpressure, early release, reset abort and data steering.
module tb_mux8_rr_sched;

  localparam int W = 16;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] d;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out_valid;
  logic       out_data;
  logic       busy;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks;
  int           errors;

  mux8_rr_sched #(.BURST_LEN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .d        (d),
    .out_ready(out_ready),
    .sel      (sel),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pack(input logic e_busy, input logic e_valid,
                                        input logic e_data, input logic [2:0] e_sel,
                                        input logic [7:0] e_gnt);
    return {2'b00, e_busy, e_valid, e_data, e_sel, e_gnt};
  endfunction

  // scoreboard
  task automatic expect_now(input string tag, input logic e_busy, input logic e_valid,
                            input logic e_data, input logic [2:0] e_sel,
                            input logic [7:0] e_gnt);
    exp_q.push_back(pack(e_busy, e_valid, e_data, e_sel, e_gnt));
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    string        tag;
    obs = pack(busy, out_valid, out_data, sel, gnt);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty obs=%h exp=entry", obs);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h (busy,valid,data,sel,gnt)", tag, obs, exp);
      end
    end
  endtask

  // driver: apply inputs for one cycle, then check state after the edge
  task automatic cyc(input string tag, input logic [7:0] r, input logic [7:0] dd,
                     input logic rdy, input logic e_busy, input logic [2:0] e_sel,
                     input logic [7:0] e_gnt);
    logic e_valid;
    logic e_data;
    e_valid = e_busy ? r[e_sel] : 1'b0;
    e_data  = e_busy ? dd[e_sel] : 1'b0;
    expect_now(tag, e_busy, e_valid, e_data, e_sel, e_gnt);
    req       = r;
    d         = dd;
    out_ready = rdy;
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    expect_now(tag, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    check_pop();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    req       = 8'h00;
    d         = 8'h00;
    out_ready = 1'b0;
    rst       = 1'b0;
    #2;

    // reset values and idle hold
    req = 8'hFF;
    d   = 8'hFF;
    do_reset("reset_state");
    cyc("idle_hold", 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00);

    // ptr = 1 via early release of channel 0, then 7 wins before 0
    do_reset("reset_b");
    cyc("b_grant0", 8'h01, 8'h00, 1'b0, 1'b1, 3'd0, 8'h01);
    cyc("b_release", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    cyc("b_grant7", 8'h81, 8'h80, 1'b1, 1'b1, 3'd7, 8'h80);
    for (int i = 0; i < 3; i++)
      cyc("b_beat7", 8'h81, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 3'd7, 8'h80);
    cyc("b_end7", 8'h81, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00);
    cyc("b_wrap0", 8'h81, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01);

    // backpressure on channel 3, then single-requester regrant
    do_reset("reset_c");
    cyc("c_grant3", 8'h08, 8'($urandom_range(0, 255)), 1'b0, 1'b1, 3'd3, 8'h08);
    for (int i = 0; i < 10; i++)
      cyc("c_hold", 8'h08, 8'($urandom_range(0, 255)), 1'b0, 1'b1, 3'd3, 8'h08);
    for (int i = 0; i < 3; i++)
      cyc("c_beat", 8'h08, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 3'd3, 8'h08);
    cyc("c_end", 8'h08, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 3'd3, 8'h00);
    cyc("c_regrant", 8'h08, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 3'd3, 8'h08);

    // channel 5 drops after two beats; others ignored meanwhile; next goes to 6
    do_reset("reset_d");
    cyc("d_grant5", 8'h20, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 3'd5, 8'h20);
    cyc("d_beat1", 8'h21, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 3'd5, 8'h20);
    cyc("d_ignore", 8'hFF, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 3'd5, 8'h20);
    cyc("d_drop", 8'h43, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 3'd5, 8'h00);
    cyc("d_next6", 8'h43, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 3'd6, 8'h40);

    // reset in the middle of channel 6's burst
    req = 8'hFF;
    d   = 8'hFF;
    #1;
    rst = 1'b1;
    #1;
    expect_now("e_rst_async", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    check_pop();
    @(posedge clk);
    #1;
    expect_now("e_rst_hold", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    check_pop();
    rst = 1'b0;
    cyc("e_restart0", 8'hFF, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 3'd0, 8'h01);

    // saturated round robin with random data: 4 beats then 1 idle per channel
    do_reset("reset_f");
    for (int j = 1; j <= 10000; j++) begin
      int         ch;
      int         ph;
      logic [7:0] g;
      ch = ((j - 1) / 5) % 8;
      ph = (j - 1) % 5;
      g  = 8'b1 << ch;
      if (j <= 41)
        cyc("rr_order", 8'hFF, 8'($urandom_range(0, 255)), 1'b1, (ph < 4), 3'(ch),
            (ph < 4) ? g : 8'h00);
      else
        cyc("rr_data", 8'hFF, 8'($urandom_range(0, 255)), 1'b1, (ph < 4), 3'(ch),
            (ph < 4) ? g : 8'h00);
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_sched.md
MUX8_RR_SCHED -- requirements
Module: mux8_rr_sched

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, meaning the maximum number of accepted beats per grant (legal range 1..16).
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  is the reset, which SHALL be asynchronous and active-high.
REQ-004 Port req  input  8  carries the per-channel requests; bit i is channel i.
REQ-005 Port d  input  8  carries the per-channel 1-bit data; bit i is the data input of channel i.
REQ-006 Port out_ready  input  1  is downstream ready.
REQ-007 Port sel  output  3  is the registered select of the granted channel.
REQ-008 Port gnt  output  8  is the registered one-hot grant, or all-zero when no channel is granted.
REQ-009 Port out_valid  output  1  SHALL indicate that a beat is offered downstream.
REQ-010 Port out_data  output  1  is the selected data, d[sel].
REQ-011 Port busy  output  1  SHALL be high while in state XFER.

Function
REQ-012 The block SHALL implement exactly two states: IDLE and XFER.
REQ-013 IDLE: if req != 0 at a clock edge, the block SHALL grant the first requester found searching upward from ptr with wrap (ptr, ptr+1, ..., 7, 0, ...); it SHALL load sel with that index, set gnt to the matching one-hot value, clear cnt and enter XFER at that edge.
REQ-014 IDLE with req == 0: the block SHALL hold state, sel and ptr, and drive gnt = 0.
REQ-015 Grant latency: req asserted before edge N SHALL give gnt/sel valid after edge N, i.e. 1 cycle.
REQ-016 XFER: out_valid SHALL be combinational and equal to req[sel]; out_data SHALL be combinational and equal to d[sel].
REQ-017 Outside XFER: out_valid SHALL be 0 and out_data SHALL be 0.
REQ-018 Beat accepted: the beat SHALL be accepted when out_valid and out_ready are both high at a clock edge; cnt (4-bit) SHALL increment on each accepted beat.
REQ-019 Burst end: an accepted beat with cnt == BURST_LEN-1 SHALL be the last beat; at that edge the block SHALL go to IDLE, set ptr = sel+1 mod 8 and clear gnt.
REQ-020 Early release: req[sel] == 0 at an edge in XFER SHALL cause a transition to IDLE at that edge, with ptr = sel+1 mod 8 and gnt cleared; no beat is accepted.
REQ-021 Backpressure: with out_ready low and req[sel] high, the block SHALL hold state, cnt and grant indefinitely.
REQ-022 Fairness: the block SHALL always spend one IDLE cycle between consecutive grants; a channel SHALL not be re-granted while any other channel requests at the arbitration edge.
REQ-023 Requests on non-granted channels during XFER SHALL be ignored until the next IDLE arbitration.
REQ-024 Single requester: a channel that is the only requester SHALL be re-granted after the 1 IDLE cycle, regardless of ptr.
REQ-025 sel SHALL retain its last value in IDLE; gnt SHALL be 0 in IDLE.

Reset
REQ-026 On rst high, the block SHALL asynchronously set state = IDLE, ptr = 0, sel = 0, cnt = 0, gnt = 0; consequently out_valid = 0, out_data = 0 and busy = 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately, with no further beats; after release, arbitration SHALL restart from ptr = 0.
REQ-028 The first arbitration edge SHALL be the first rising edge of clk with rst low.

Verification
REQ-029 The bench SHALL cover: rst pulse mid-XFER -> gnt = 0, out_valid = 0 immediately; after release, req = 8'hFF -> sel = 0 granted.
REQ-030 The bench SHALL cover: req = 8'hFF held, out_ready = 1, BURST_LEN = 4 -> grants in order 0,1,...,7,0, each with 4 beats followed by 1 IDLE cycle, for a period of 40 cycles.
REQ-031 The bench SHALL cover: req = 8'b1000_0001 with ptr = 1 -> channel 7 granted first, then channel 0 (wrap-around).
REQ-032 The bench SHALL cover: grant on channel 3, out_ready = 0 for 10 cycles -> cnt, sel = 3 and gnt = 8'h08 held; out_valid = 1 throughout.
REQ-033 The bench SHALL cover: grant on channel 5, req[5] dropped after 2 accepted beats -> IDLE next edge, ptr = 6, with the next grant going to the lowest requester at or after 6.
REQ-034 The bench SHALL cover: out_data compared against d[sel] on every accepted beat for random d, with zero mismatches over 10,000 cycles.
